// File: rtl/adc_conv.sv
// adc_conv: one LTC1407A dual-channel conversion per controller trigger.
//
// A trigger in IDLE starts a frame: an AD_CONV pulse (CLK_DIV cycles high,
// CLK_DIV cycles low), then 34 SCK periods. spi_miso is sampled on the clock
// edge that raises spi_sck. Of the 34 bits, k=2..15 form adc_a and k=18..31
// form adc_b, MSB first; the rest are dropped. One DONE cycle follows, after
// which the samples are presented together with a one-cycle adc_done pulse.
//
// Ports
//   CLK50MHZ  in   system clock
//   RST       in   asynchronous reset, active low
//   adc_trig  in   start request, ignored unless idle
//   adc_done  out  one-cycle pulse, adc_a/adc_b just updated
//   adc_a     out  channel 0 sample (14b two's complement), held
//   adc_b     out  channel 1 sample (14b two's complement), held
//   busy      out  accepted trigger through the adc_done cycle
//   ad_conv   out  ADC conversion-start pin
//   spi_sck   out  SPI clock, idles low
//   spi_miso  in   ADC serial data
//
// Trigger-to-adc_done latency is 70*CLK_DIV+1 cycles.
module adc_conv #(
  parameter int CLK_DIV = 2  // half-period of spi_sck in clock cycles, >= 1
) (
  input  logic        CLK50MHZ,
  input  logic        RST,
  input  logic        adc_trig,
  output logic        adc_done,
  output logic [13:0] adc_a,
  output logic [13:0] adc_b,
  output logic        busy,
  output logic        ad_conv,
  output logic        spi_sck,
  input  logic        spi_miso
);

  localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  // SHIFT walks 68 half-periods; even = sck low, odd = sck high.
  localparam logic [6:0]      PH_LAST  = 7'd67;

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t        state_q, state_n;
  logic [DW-1:0] div_q, div_n;
  logic [6:0]    ph_q, ph_n;
  logic [27:0]   sreg_q, sreg_n;
  logic          done_q, done_n;
  logic          busy_q, busy_n;
  logic          conv_q, conv_n;
  logic          sck_q, sck_n;
  logic [13:0]   a_q, a_n;
  logic [13:0]   b_q, b_n;

  logic          div_end;
  logic [5:0]    bit_k;
  logic          keep;

  assign div_end = (div_q == DIV_LAST);
  // Bit index of the SCK period currently in progress.
  assign bit_k   = ph_q[6:1];
  // Only the 28 payload bits are shifted in, so after a full frame the
  // register holds {adc_a, adc_b} with no dead bits to strip.
  assign keep    = ((bit_k >= 6'd2)  && (bit_k <= 6'd15)) ||
                   ((bit_k >= 6'd18) && (bit_k <= 6'd31));

  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    ph_n    = ph_q;
    sreg_n  = sreg_q;
    done_n  = 1'b0;
    busy_n  = busy_q;
    conv_n  = conv_q;
    sck_n   = sck_q;
    a_n     = a_q;
    b_n     = b_q;

    case (state_q)
      IDLE: begin
        // busy is held through the first IDLE cycle after DONE so it covers
        // the adc_done cycle; it drops here unless a new frame starts.
        busy_n = 1'b0;
        conv_n = 1'b0;
        sck_n  = 1'b0;
        if (adc_trig) begin
          state_n = CONV;
          busy_n  = 1'b1;
          conv_n  = 1'b1;
          div_n   = '0;
          ph_n    = '0;
        end
      end

      CONV: begin
        div_n = div_end ? '0 : div_q + DW'(1);
        if (div_end) begin
          if (ph_q == 7'd0) begin
            ph_n   = 7'd1;
            conv_n = 1'b0;
          end else begin
            state_n = SHIFT;
            ph_n    = '0;
          end
        end
      end

      SHIFT: begin
        div_n = div_end ? '0 : div_q + DW'(1);
        if (div_end) begin
          if (!ph_q[0]) begin
            // Rising SCK edge: this is the sampling edge.
            sck_n = 1'b1;
            if (keep) sreg_n = {sreg_q[26:0], spi_miso};
            ph_n = ph_q + 7'd1;
          end else begin
            sck_n = 1'b0;
            if (ph_q == PH_LAST) state_n = DONE;
            else                 ph_n    = ph_q + 7'd1;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
        done_n  = 1'b1;
        a_n     = sreg_q[27:14];
        b_n     = sreg_q[13:0];
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      div_q   <= '0;
      ph_q    <= '0;
      sreg_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      conv_q  <= 1'b0;
      sck_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      ph_q    <= ph_n;
      sreg_q  <= sreg_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      conv_q  <= conv_n;
      sck_q   <= sck_n;
      a_q     <= a_n;
      b_q     <= b_n;
    end
  end

  assign adc_done = done_q;
  assign busy     = busy_q;
  assign ad_conv  = conv_q;
  assign spi_sck  = sck_q;
  assign adc_a    = a_q;
  assign adc_b    = b_q;

endmodule

// File: tb/tb_adc_conv.sv
// Bench for adc_conv: two instances (CLK_DIV=2 and CLK_DIV=1), each with a
// behavioural LTC1407A that shifts out a 34-bit frame on SCK falling edges.
module tb_adc_conv;

  logic CLK50MHZ = 1'b0;
  logic RST      = 1'b0;
  always #5 CLK50MHZ = ~CLK50MHZ;

  int cyc = 0;
  always @(posedge CLK50MHZ) cyc <= cyc + 1;

  logic        trig2 = 1'b0, trig1 = 1'b0;
  logic        miso2 = 1'b0, miso1 = 1'b0;
  logic        done2, busy2, conv2, sck2;
  logic        done1, busy1, conv1, sck1;
  logic [13:0] a2, b2, a1, b1;

  adc_conv #(.CLK_DIV(2)) u_dut2 (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .adc_trig(trig2), .adc_done(done2),
    .adc_a(a2), .adc_b(b2), .busy(busy2), .ad_conv(conv2),
    .spi_sck(sck2), .spi_miso(miso2)
  );

  adc_conv #(.CLK_DIV(1)) u_dut1 (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .adc_trig(trig1), .adc_done(done1),
    .adc_a(a1), .adc_b(b1), .busy(busy1), .ad_conv(conv1),
    .spi_sck(sck1), .spi_miso(miso1)
  );

  // ADC frame, bit k at position 33-k.
  function automatic logic [33:0] mk_frame(logic [13:0] a, logic [13:0] b, logic pad);
    return {{2{pad}}, a, {2{pad}}, b, {2{pad}}};
  endfunction

  // ---------------- ADC model + monitor, CLK_DIV=2 ----------------
  logic [33:0] frm2 = '0;
  bit          noise2 = 1'b0;
  logic        psck2 = 1'b0, pconv2 = 1'b0, busyd2 = 1'b0;
  logic [13:0] acap2 = '0, bcap2 = '0;
  int idx2 = 0, run2 = 0, rises2 = 0, fr2 = 0, frd2 = 0;
  int dones2 = 0, done_cyc2 = 0, convhi2 = 0, phbad2 = 0;

  always @(negedge CLK50MHZ) begin
    if (!RST) begin
      psck2 = 1'b0; pconv2 = 1'b0; miso2 = 1'b0; idx2 = 0; run2 = 0;
    end else begin
      if (conv2 && !pconv2) begin idx2 = 0; fr2 = 0; miso2 = frm2[33]; end
      if (sck2 != psck2) begin
        if ((psck2 || fr2 > 0) && run2 != 2) phbad2++;
        run2 = 0;
        if (sck2) begin rises2++; fr2++; end
        else begin
          idx2++;
          miso2 = (idx2 < 34) ? frm2[33-idx2] : 1'b0;
        end
      end
      run2++;
      if (conv2) convhi2++;
      if (done2) begin
        dones2++; done_cyc2 = cyc; acap2 = a2; bcap2 = b2; busyd2 = busy2; frd2 = fr2;
      end
      if (noise2) miso2 = 1'($urandom);
      psck2 = sck2; pconv2 = conv2;
    end
  end

  // ---------------- ADC model + monitor, CLK_DIV=1 ----------------
  logic [33:0] frm1 = '0;
  logic        psck1 = 1'b0, pconv1 = 1'b0, busyd1 = 1'b0;
  logic [13:0] acap1 = '0, bcap1 = '0;
  int idx1 = 0, run1 = 0, rises1 = 0, fr1 = 0, frd1 = 0;
  int dones1 = 0, done_cyc1 = 0, convhi1 = 0, phbad1 = 0;

  always @(negedge CLK50MHZ) begin
    if (!RST) begin
      psck1 = 1'b0; pconv1 = 1'b0; miso1 = 1'b0; idx1 = 0; run1 = 0;
    end else begin
      if (conv1 && !pconv1) begin idx1 = 0; fr1 = 0; miso1 = frm1[33]; end
      if (sck1 != psck1) begin
        if ((psck1 || fr1 > 0) && run1 != 1) phbad1++;
        run1 = 0;
        if (sck1) begin rises1++; fr1++; end
        else begin
          idx1++;
          miso1 = (idx1 < 34) ? frm1[33-idx1] : 1'b0;
        end
      end
      run1++;
      if (conv1) convhi1++;
      if (done1) begin
        dones1++; done_cyc1 = cyc; acap1 = a1; bcap1 = b1; busyd1 = busy1; frd1 = fr1;
      end
      psck1 = sck1; pconv1 = conv1;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int   g_dones (int s); return s ? dones1    : dones2;    endfunction
  function automatic int   g_dcyc  (int s); return s ? done_cyc1 : done_cyc2; endfunction
  function automatic int   g_convhi(int s); return s ? convhi1   : convhi2;   endfunction
  function automatic int   g_phbad (int s); return s ? phbad1    : phbad2;    endfunction
  function automatic int   g_frd   (int s); return s ? frd1      : frd2;      endfunction
  function automatic logic [13:0] g_acap(int s); return s ? acap1 : acap2; endfunction
  function automatic logic [13:0] g_bcap(int s); return s ? bcap1 : bcap2; endfunction
  function automatic logic g_busyd (int s); return s ? busyd1    : busyd2;    endfunction
  function automatic logic g_busy  (int s); return s ? busy1     : busy2;     endfunction
  function automatic logic g_done  (int s); return s ? done1     : done2;     endfunction

  task automatic drive_trig(input int s, input logic v);
    if (s != 0) trig1 = v; else trig2 = v;
  endtask

  task automatic set_frm(input int s, input logic [33:0] f);
    if (s != 0) frm1 = f; else frm2 = f;
  endtask

  task automatic tick;
    @(negedge CLK50MHZ);
    #1;
  endtask

  task automatic wait_done(input int s, input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (g_dones(s) > d0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // One full frame on instance s (0: CLK_DIV=2, 1: CLK_DIV=1).
  task automatic run_frame(input int s, input logic [13:0] a, input logic [13:0] b,
                           input logic pad);
    int cd, d0, c0, p0, t0;
    bit ok;
    cd = (s != 0) ? 1 : 2;
    set_frm(s, mk_frame(a, b, pad));
    d0 = g_dones(s); c0 = g_convhi(s); p0 = g_phbad(s);
    drive_trig(s, 1'b1);
    t0 = cyc + 1;
    tick();
    drive_trig(s, 1'b0);
    chk("busy_start", 32'(g_busy(s)), 32'd1);
    wait_done(s, d0, ok);
    chk("done_seen", 32'(ok), 32'd1);
    chk("latency", g_dcyc(s) - t0, 70 * cd + 1);
    chk("adc_a", 32'(g_acap(s)), 32'(a));
    chk("adc_b", 32'(g_bcap(s)), 32'(b));
    chk("busy_at_done", 32'(g_busyd(s)), 32'd1);
    chk("sck_rises", g_frd(s), 34);
    chk("conv_high_cycles", g_convhi(s) - c0, cd);
    chk("sck_phase_len", g_phbad(s) - p0, 0);
    chk("done_count", g_dones(s) - d0, 1);
    tick();
    chk("idle_after_done", {30'd0, g_done(s), g_busy(s)}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad2, bad1, r0, d0, t0, t1;
    bit ok;
    logic [13:0] ra, rb;

    // Reset held with triggers toggling: nothing may move.
    bad2 = 0; bad1 = 0;
    for (int i = 0; i < 12; i++) begin
      trig2 = 1'(i); trig1 = 1'(~i);
      tick();
      if ({done2, busy2, conv2, sck2, a2, b2} != 0) bad2++;
      if ({done1, busy1, conv1, sck1, a1, b1} != 0) bad1++;
    end
    trig2 = 1'b0; trig1 = 1'b0;
    chk("rst_outputs_d2", bad2, 0);
    chk("rst_outputs_d1", bad1, 0);
    chk("rst_sck_edges", rises2 + rises1, 0);
    RST = 1'b1;
    repeat (3) tick();

    // Basic and boundary frames.
    run_frame(0, 14'h2ABC, 14'h1543, 1'b0);
    run_frame(0, 14'h3FFF, 14'h0000, 1'b1);
    run_frame(0, 14'h2000, 14'h1FFF, 1'b1);

    // Idle hold with noisy MISO.
    bad2 = 0; r0 = rises2; d0 = dones2;
    noise2 = 1'b1;
    repeat (500) begin
      tick();
      if (a2 !== 14'h2000 || b2 !== 14'h1FFF || sck2 !== 1'b0 || done2 !== 1'b0) bad2++;
    end
    noise2 = 1'b0;
    chk("hold_stable", bad2, 0);
    chk("hold_sck_edges", rises2 - r0, 0);
    chk("hold_no_done", dones2 - d0, 0);

    // Triggers while busy are dropped; trigger right after done is taken.
    set_frm(0, mk_frame(14'h1234, 14'h0DEF, 1'b1));
    d0 = dones2;
    trig2 = 1'b1; t0 = cyc + 1; tick(); trig2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (dones2 > d0) begin ok = 1'b1; break; end
      trig2 = (cyc + 1 == t0 + 5) || (cyc + 1 == t0 + 60) || (cyc + 1 == t0 + 140);
      tick();
    end
    trig2 = 1'b0;
    chk("busy_done_seen", 32'(ok), 32'd1);
    chk("busy_latency", done_cyc2 - t0, 141);
    chk("busy_adc_a", 32'(acap2), 32'h1234);
    set_frm(0, mk_frame(14'h3ABC, 14'h0155, 1'b0));
    trig2 = 1'b1; t1 = cyc + 1; tick(); trig2 = 1'b0;
    chk("retrig_after_done", t1 - t0, 142);
    wait_done(0, d0 + 1, ok);
    chk("retrig_latency", done_cyc2 - t1, 141);
    chk("retrig_adc_a", 32'(acap2), 32'h3ABC);
    chk("retrig_adc_b", 32'(bcap2), 32'h0155);
    repeat (300) tick();
    chk("busy_total_dones", dones2 - d0, 2);

    // CLK_DIV=1 instance.
    run_frame(1, 14'h0001, 14'h2000, 1'b1);

    // Randomized frames on both instances.
    for (int i = 0; i < 4; i++) begin
      ra = 14'($urandom); rb = 14'($urandom);
      run_frame(0, ra, rb, 1'($urandom));
      ra = 14'($urandom); rb = 14'($urandom);
      run_frame(1, ra, rb, 1'($urandom));
    end

    // Reset mid-SHIFT (period 10).
    set_frm(0, mk_frame(14'h2ABC, 14'h1543, 1'b1));
    d0 = dones2;
    trig2 = 1'b1; tick(); trig2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fr2 >= 10) begin ok = 1'b1; break; end
      tick();
    end
    chk("mid_rst_reached", 32'(ok), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_outputs", {sck2, conv2, busy2, done2, a2, b2}, 32'd0);
    repeat (5) tick();
    RST = 1'b1;
    repeat (200) tick();
    chk("mid_rst_no_done", dones2 - d0, 0);
    run_frame(0, 14'h0ACE, 14'h3001, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
